// File: rtl/pc_stack_if.sv
// rtl/pc_stack_if.sv - control, target and status bundle between the fetch stage and pc_stack
interface pc_stack_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
);
   logic [WIDTH-1:0]           in;
   logic [WIDTH-1:0]           offset;
   logic                       load;
   logic                       call;
   logic                       ret;
   logic                       rel;
   logic                       inc;
   logic                       clr_err;
   logic [WIDTH-1:0]           out;
   logic [$clog2(DEPTH+1)-1:0] depth;
   logic                       full;
   logic                       empty;
   logic                       err;

   modport master (
      output in, offset, load, call, ret, rel, inc, clr_err,
      input  out, depth, full, empty, err
   );

   modport slave (
      input  in, offset, load, call, ret, rel, inc, clr_err,
      output out, depth, full, empty, err
   );
endinterface

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with relative branch and call/return stack; PC_STACK_TRAP_EN redirects to TRAP_VEC on stack error
module pc_stack #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC  = '1
) (
   input logic        clk,
   input logic        reset,
   pc_stack_if.slave  bus
);
   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [DW-1:0]    ONE_D  = DW'(1);
   localparam logic [DW-1:0]    FULL_D = DW'(DEPTH);
   localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

   logic [WIDTH-1:0] stack [DEPTH];
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic [DW-1:0]    top_idx;
   logic             err_q, err_d, err_set;
   logic             push;
   logic             full, empty;
   logic [WIDTH-1:0] fault_pc;

   assign full    = (depth_q == FULL_D);
   assign empty   = (depth_q == '0);
   assign top_idx = depth_q - ONE_D;

`ifdef PC_STACK_TRAP_EN
   assign fault_pc = TRAP_VEC;
`else
   logic unused_trap_vec;
   assign unused_trap_vec = ^TRAP_VEC;
   assign fault_pc        = pc_q;
`endif

   // Strict priority: load > call > ret > rel > inc > hold.
   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      err_set = 1'b0;
      push    = 1'b0;
      if (bus.load) begin
         pc_d = bus.in;
      end else if (bus.call) begin
         if (full) begin
            err_set = 1'b1;
            pc_d    = fault_pc;
         end else begin
            push    = 1'b1;
            depth_d = depth_q + ONE_D;
            pc_d    = bus.in;
         end
      end else if (bus.ret) begin
         if (empty) begin
            err_set = 1'b1;
            pc_d    = fault_pc;
         end else begin
            depth_d = top_idx;
            pc_d    = stack[top_idx[AW-1:0]];
         end
      end else if (bus.rel) begin
         pc_d = pc_q + bus.offset;
      end else if (bus.inc) begin
         pc_d = pc_q + ONE_W;
      end
      // A new error outranks a same-cycle clear.
      err_d = err_set | (err_q & ~bus.clr_err);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_VEC;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
      end
   end

   // Return-address storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[depth_q[AW-1:0]] <= pc_q + ONE_W;
      end
   end

   assign bus.out   = pc_q;
   assign bus.depth = depth_q;
   assign bus.full  = full;
   assign bus.empty = empty;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - directed self-checking bench for pc_stack
module tb_pc_stack;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

`ifdef PC_STACK_TRAP_EN
   localparam logic [15:0] OVF_PC = 16'hFFFF;
   localparam logic [15:0] UDF_PC = 16'hFFFF;
`else
   localparam logic [15:0] OVF_PC = 16'h4007;
   localparam logic [15:0] UDF_PC = 16'h0000;
`endif

   pc_stack_if #(.WIDTH(16), .DEPTH(8)) bus ();

   pc_stack #(.WIDTH(16), .DEPTH(8)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.in      = '0;
      bus.offset  = '0;
      bus.load    = 1'b0;
      bus.call    = 1'b0;
      bus.ret     = 1'b0;
      bus.rel     = 1'b0;
      bus.inc     = 1'b0;
      bus.clr_err = 1'b0;
   endtask

   // One clock with the given request set; outputs are sampled 1ns after the edge.
   task automatic go(input logic l, input logic c, input logic r, input logic rl,
                     input logic i, input logic ce, input logic [15:0] a,
                     input logic [15:0] off);
      bus.load    = l;
      bus.call    = c;
      bus.ret     = r;
      bus.rel     = rl;
      bus.inc     = i;
      bus.clr_err = ce;
      bus.in      = a;
      bus.offset  = off;
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();
      #12;
      chk("reset_out",   32'(bus.out),   32'h0000);
      chk("reset_depth", 32'(bus.depth), 32'h0);
      chk("reset_err",   32'(bus.err),   32'h0);
      chk("reset_empty", 32'(bus.empty), 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out", 32'(bus.out), 32'h0000);

      go(1, 0, 0, 0, 0, 0, 16'hABCD, 16'h0);
      chk("load_abcd", 32'(bus.out), 32'hABCD);
      go(0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
      go(0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
      chk("inc2", 32'(bus.out), 32'hABCF);
      go(0, 1, 0, 0, 0, 0, 16'h5000, 16'h0);
      chk("call_pre_rst_depth", 32'(bus.depth), 32'h1);
      rst_n = 1'b0;
      #2;
      chk("async_rst_out",   32'(bus.out),   32'h0000);
      chk("async_rst_depth", 32'(bus.depth), 32'h0);
      rst_n = 1'b1;

      go(1, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0);
      go(0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
      chk("inc_wrap", 32'(bus.out), 32'h0000);
      go(1, 0, 0, 0, 0, 0, 16'h0010, 16'h0);
      go(0, 0, 0, 1, 0, 0, 16'h0, 16'hFFFE);
      chk("rel_neg", 32'(bus.out), 32'h000E);
      go(0, 0, 0, 1, 0, 0, 16'h0, 16'h0005);
      chk("rel_pos", 32'(bus.out), 32'h0013);

      go(1, 0, 0, 0, 0, 0, 16'h1000, 16'h0);
      go(0, 1, 0, 0, 0, 0, 16'h2000, 16'h0);
      chk("call1_out",   32'(bus.out),   32'h2000);
      chk("call1_depth", 32'(bus.depth), 32'h1);
      go(0, 1, 0, 0, 0, 0, 16'h3000, 16'h0);
      chk("call2_out",   32'(bus.out),   32'h3000);
      chk("call2_depth", 32'(bus.depth), 32'h2);
      go(0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
      chk("ret1_out", 32'(bus.out), 32'h2001);
      go(0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
      chk("ret2_out",   32'(bus.out),   32'h1001);
      chk("ret2_depth", 32'(bus.depth), 32'h0);
      chk("ret2_empty", 32'(bus.empty), 32'h1);

      // Stack after the loop: 1002, 4001 .. 4007.
      for (int k = 0; k < 8; k++) begin
         go(0, 1, 0, 0, 0, 0, 16'h4000 + 16'(k), 16'h0);
      end
      chk("fill_full",  32'(bus.full),  32'h1);
      chk("fill_depth", 32'(bus.depth), 32'h8);
      chk("fill_err",   32'(bus.err),   32'h0);
      go(0, 1, 0, 0, 0, 0, 16'h4444, 16'h0);
      chk("ovf_depth", 32'(bus.depth), 32'h8);
      chk("ovf_err",   32'(bus.err),   32'h1);
      chk("ovf_out",   32'(bus.out),   32'(OVF_PC));
      go(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      chk("ovf_clr", 32'(bus.err), 32'h0);
      go(0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
      chk("ovf_ret_out",   32'(bus.out),   32'h4007);
      chk("ovf_ret_depth", 32'(bus.depth), 32'h7);

      do_reset();
      go(0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
      chk("udf_err",   32'(bus.err),   32'h1);
      chk("udf_depth", 32'(bus.depth), 32'h0);
      chk("udf_out",   32'(bus.out),   32'(UDF_PC));
      go(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      chk("udf_clr", 32'(bus.err), 32'h0);
      go(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
      chk("udf_set_wins", 32'(bus.err), 32'h1);

      do_reset();
      go(1, 0, 0, 0, 0, 0, 16'h0100, 16'h0);
      go(1, 1, 0, 0, 1, 0, 16'h0200, 16'h0);
      chk("prio_load_out",   32'(bus.out),   32'h0200);
      chk("prio_load_depth", 32'(bus.depth), 32'h0);
      go(0, 1, 1, 0, 1, 0, 16'h0300, 16'h0);
      chk("prio_call_out",   32'(bus.out),   32'h0300);
      chk("prio_call_depth", 32'(bus.depth), 32'h1);
      go(0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
      chk("prio_call_top", 32'(bus.out), 32'h0201);
      go(0, 0, 0, 1, 1, 0, 16'h0, 16'h0010);
      chk("prio_rel_inc", 32'(bus.out), 32'h0211);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
